// File: rtl/enemy_run_sequencer.sv
// Motion, animation and life-cycle controller for one running enemy sprite.
// Valid/ready does not apply: spawn/kill are sampled levels and frame_tick is a one-cycle strobe.
`timescale 1ns/1ps
module enemy_run_sequencer #(
    parameter int SPRITE_W   = 40,
    parameter int SPRITE_H   = 66,
    parameter int X_START    = 600,
    parameter int Y_GROUND   = 300,
    parameter int SPEED      = 2,
    parameter int FRAME_HOLD = 6,
    parameter int DIE_TICKS  = 32
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        spawn,
    input  logic        kill,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        sprite_on,
    output logic [12:0] rom_address,
    output logic [1:0]  frame_sel,
    output logic [9:0]  enemy_x,
    output logic [9:0]  enemy_y,
    output logic        active,
    output logic        exited,
    output logic [1:0]  state_dbg
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int DIE_W  = (DIE_TICKS > 8) ? $clog2(DIE_TICKS) : 3;

    localparam logic [9:0]        X_START_V  = 10'(X_START);
    localparam logic [9:0]        Y_GROUND_V = 10'(Y_GROUND);
    localparam logic [9:0]        SPEED_V    = 10'(SPEED);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [DIE_W-1:0]  DIE_MAX    = DIE_W'(DIE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DYING = 2'd2
    } state_t;

    state_t            state_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [1:0]        frame_q;
    logic [HOLD_W-1:0] hold_q;
    logic [DIE_W-1:0]  die_q;
    logic              active_q;
    logic              exited_q;
    logic              sprite_on_q;
    logic [12:0]       rom_q;

    // Life-cycle FSM; every output it drives is registered here.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            x_q      <= X_START_V;
            y_q      <= Y_GROUND_V;
            frame_q  <= 2'd0;
            hold_q   <= '0;
            die_q    <= '0;
            active_q <= 1'b0;
            exited_q <= 1'b0;
        end else begin
            exited_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (spawn) begin
                        state_q  <= S_RUN;
                        active_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    // kill has priority over a coincident frame_tick
                    if (kill) begin
                        state_q <= S_DYING;
                        die_q   <= '0;
                    end else if (frame_tick) begin
                        if (x_q < SPEED_V) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                            exited_q <= 1'b1;
                            x_q      <= X_START_V;
                            frame_q  <= 2'd0;
                            hold_q   <= '0;
                        end else begin
                            x_q <= x_q - SPEED_V;
                            if (hold_q == HOLD_MAX) begin
                                hold_q  <= '0;
                                frame_q <= frame_q + 2'd1;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                    end
                end
                S_DYING: begin
                    if (frame_tick) begin
                        if (die_q == DIE_MAX) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                            x_q      <= X_START_V;
                            frame_q  <= 2'd0;
                            hold_q   <= '0;
                            die_q    <= '0;
                        end else begin
                            die_q <= die_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Pixel path: 11-bit compares keep x+SPRITE_W from wrapping at the right edge.
    logic [10:0] px, py, x11, y11, dx, dy;
    logic        hit, visible, sprite_on_d;
    logic [12:0] rom_d;

    assign px  = {1'b0, DrawX};
    assign py  = {1'b0, DrawY};
    assign x11 = {1'b0, x_q};
    assign y11 = {1'b0, y_q};
    assign dx  = px - x11;
    assign dy  = py - y11;

    assign hit = (px >= x11) && (px < x11 + 11'(SPRITE_W)) &&
                 (py >= y11) && (py < y11 + 11'(SPRITE_H));

    assign visible     = (state_q == S_RUN) || ((state_q == S_DYING) && !die_q[2]);
    assign sprite_on_d = hit && visible;
    assign rom_d       = hit ? ({2'b00, dy} * 13'(SPRITE_W) + {2'b00, dx}) : 13'd0;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            sprite_on_q <= 1'b0;
            rom_q       <= 13'd0;
        end else begin
            sprite_on_q <= sprite_on_d;
            rom_q       <= rom_d;
        end
    end

    assign sprite_on   = sprite_on_q;
    assign rom_address = rom_q;
    assign frame_sel   = frame_q;
    assign enemy_x     = x_q;
    assign enemy_y     = y_q;
    assign active      = active_q;
    assign exited      = exited_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_enemy_run_sequencer.sv
// Directed self-checking bench for enemy_run_sequencer: spawn, run, animate, exit, kill/blink, async reset.
`timescale 1ns/1ps
module tb_enemy_run_sequencer;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        spawn;
  logic        kill;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        sprite_on;
  logic [12:0] rom_address;
  logic [1:0]  frame_sel;
  logic [9:0]  enemy_x;
  logic [9:0]  enemy_y;
  logic        active;
  logic        exited;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  enemy_run_sequencer dut (
    .vga_clk     (clk),
    .Reset       (rst),
    .frame_tick  (frame_tick),
    .spawn       (spawn),
    .kill        (kill),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .sprite_on   (sprite_on),
    .rom_address (rom_address),
    .frame_sel   (frame_sel),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .active      (active),
    .exited      (exited),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(state_dbg),   32'd0);
    check({tag, "_x"},      32'(enemy_x),     32'd600);
    check({tag, "_y"},      32'(enemy_y),     32'd300);
    check({tag, "_frame"},  32'(frame_sel),   32'd0);
    check({tag, "_active"}, 32'(active),      32'd0);
    check({tag, "_exited"}, 32'(exited),      32'd0);
    check({tag, "_son"},    32'(sprite_on),   32'd0);
    check({tag, "_rom"},    32'(rom_address), 32'd0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; spawn = 1'b0; kill = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0;
    #1;
    check_reset_values("rst");
    step(); step();
    rst = 1'b0;
    step();
    check_reset_values("idle");

    // IDLE: geometric hit still yields an address, but the sprite stays invisible
    draw_x = 10'd610; draw_y = 10'd301;
    step();
    check("idle_son", 32'(sprite_on), 32'd0);
    check("idle_rom", 32'(rom_address), 32'd50);

    // kill ignored outside RUN
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_idle_state", 32'(state_dbg), 32'd0);

    // spawn without frame_tick
    spawn = 1'b1;
    step();
    spawn = 1'b0;
    check("spawn_active", 32'(active), 32'd1);
    check("spawn_state", 32'(state_dbg), 32'd1);

    draw_x = 10'd600; draw_y = 10'd300;
    step();
    check("tl_son", 32'(sprite_on), 32'd1);
    check("tl_rom", 32'(rom_address), 32'd0);
    draw_x = 10'd639; draw_y = 10'd365;
    step();
    check("br_son", 32'(sprite_on), 32'd1);
    check("br_rom", 32'(rom_address), 32'd2639);
    draw_x = 10'd599; draw_y = 10'd300;
    step();
    check("left_son", 32'(sprite_on), 32'd0);
    check("left_rom", 32'(rom_address), 32'd0);
    draw_x = 10'd640; draw_y = 10'd300;
    step();
    check("right_son", 32'(sprite_on), 32'd0);
    check("right_rom", 32'(rom_address), 32'd0);
    draw_x = 10'd600; draw_y = 10'd366;
    step();
    check("below_son", 32'(sprite_on), 32'd0);
    check("below_rom", 32'(rom_address), 32'd0);
    draw_x = 10'd620; draw_y = 10'd299;
    step();
    check("above_son", 32'(sprite_on), 32'd0);

    // 24 ticks: frame advances on ticks 6, 12, 18, 24
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp_q.push_back(32'd3); exp_q.push_back(32'd0);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i % 6 == 0) check($sformatf("frame_t%0d", i), 32'(frame_sel), exp_q.pop_front());
      if (i == 5) check("frame_t5", 32'(frame_sel), 32'd0);
    end
    check("x_552", 32'(enemy_x), 32'd552);
    check("y_fixed", 32'(enemy_y), 32'd300);

    // 26 more ticks to x=500 (50 ticks total: frame back to 0)
    for (int i = 0; i < 26; i++) tick();
    check("x_500", 32'(enemy_x), 32'd500);

    // kill + frame_tick together: no move, no frame change
    kill = 1'b1; frame_tick = 1'b1;
    step();
    kill = 1'b0; frame_tick = 1'b0;
    check("kill_state", 32'(state_dbg), 32'd2);
    check("kill_x", 32'(enemy_x), 32'd500);
    check("kill_frame", 32'(frame_sel), 32'd0);
    check("kill_active", 32'(active), 32'd1);
    draw_x = 10'd500; draw_y = 10'd300;
    step();
    check("die0_son", 32'(sprite_on), 32'd1);

    // blink: invisible whenever die count bit 2 is set
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) spawn = 1'b1;
      tick();
      spawn = 1'b0;
      check($sformatf("blink_%0d", k), 32'(sprite_on), ((k >> 2) & 1) ? 32'd0 : 32'd1);
      check($sformatf("die_exit_%0d", k), 32'(exited), 32'd0);
    end
    check("die_state", 32'(state_dbg), 32'd2);
    check("die_x", 32'(enemy_x), 32'd500);

    // 32nd tick ends DYING without an exited pulse
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("dead_state", 32'(state_dbg), 32'd0);
    check("dead_active", 32'(active), 32'd0);
    check("dead_x", 32'(enemy_x), 32'd600);
    check("dead_exited", 32'(exited), 32'd0);
    step();
    check("dead_exited2", 32'(exited), 32'd0);
    check("dead_son", 32'(sprite_on), 32'd0);

    // run off screen left: 300 ticks to x=0, then the exit tick
    spawn = 1'b1;
    step();
    spawn = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    check("x_zero", 32'(enemy_x), 32'd0);
    check("run_state", 32'(state_dbg), 32'd1);
    draw_x = 10'd0; draw_y = 10'd300;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("exit_state", 32'(state_dbg), 32'd0);
    check("exit_pulse", 32'(exited), 32'd1);
    check("exit_x", 32'(enemy_x), 32'd600);
    check("exit_active", 32'(active), 32'd0);
    check("exit_frame", 32'(frame_sel), 32'd0);
    step();
    check("exit_pulse_end", 32'(exited), 32'd0);
    check("exit_son", 32'(sprite_on), 32'd0);

    // async reset mid-DYING with frame_sel=1 and sprite visible
    spawn = 1'b1;
    step();
    spawn = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_x", 32'(enemy_x), 32'd588);
    check("pre_frame", 32'(frame_sel), 32'd1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    tick();
    draw_x = 10'd598; draw_y = 10'd310;
    step();
    check("pre_state", 32'(state_dbg), 32'd2);
    check("pre_son", 32'(sprite_on), 32'd1);
    check("pre_rom", 32'(rom_address), 32'd410);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    step();
    rst = 1'b0;
    step();
    check("post_rst_state", 32'(state_dbg), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
